// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm-time writer: state encoding (equal to edit_field),
// BCD field limits and the default reset time and timing constants.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_EDIT_HOUR = 2'b01,
        ST_EDIT_MIN  = 2'b10
    } state_e;

    localparam logic [7:0] HOUR_MAX       = 8'h23;
    localparam logic [7:0] MIN_MAX        = 8'h59;
    localparam logic [7:0] RESET_HOUR_DEF = 8'h06;
    localparam logic [7:0] RESET_MIN_DEF  = 8'h30;

    localparam int unsigned HOLD_CYCLES_DEF   = 50_000_000;
    localparam int unsigned REPEAT_CYCLES_DEF = 10_000_000;
    localparam int unsigned BLINK_CYCLES_DEF  = 25_000_000;

endpackage

// File: rtl/alarm_time_set_if.sv
// Key inputs and alarm/display outputs of the alarm-time writer.
// Keys are debounced, synchronized levels; an action fires on a sampled rising edge.
interface alarm_time_set_if;

    logic       key_mode;
    logic       key_sel;
    logic       key_inc;
    logic       key_dec;
    logic [3:0] alarm_hour_10;
    logic [3:0] alarm_hour_01;
    logic [3:0] alarm_min_10;
    logic [3:0] alarm_min_01;
    logic [3:0] edit_hour_10;
    logic [3:0] edit_hour_01;
    logic [3:0] edit_min_10;
    logic [3:0] edit_min_01;
    logic [1:0] edit_field;
    logic       blink;

    modport master (
        output key_mode, key_sel, key_inc, key_dec,
        input  alarm_hour_10, alarm_hour_01, alarm_min_10, alarm_min_01,
        input  edit_hour_10, edit_hour_01, edit_min_10, edit_min_01,
        input  edit_field, blink
    );

    modport slave (
        input  key_mode, key_sel, key_inc, key_dec,
        output alarm_hour_10, alarm_hour_01, alarm_min_10, alarm_min_01,
        output edit_hour_10, edit_hour_01, edit_min_10, edit_min_01,
        output edit_field, blink
    );

endinterface

// File: rtl/alarm_bcd_step.sv
// Combinational two-digit BCD step with wrap between 00 and max.
// up and down together (or neither) leave the value unchanged.
module alarm_bcd_step (
    input  logic [7:0] value,
    input  logic [7:0] max,
    input  logic       up,
    input  logic       down,
    output logic [7:0] next
);

    always_comb begin
        next = value;
        if (up && !down) begin
            if (value == max)
                next = 8'h00;
            else if (value[3:0] == 4'd9)
                next = {value[7:4] + 4'd1, 4'd0};
            else
                next = {value[7:4], value[3:0] + 4'd1};
        end else if (down && !up) begin
            if (value == 8'h00)
                next = max;
            else if (value[3:0] == 4'd0)
                next = {value[7:4] - 4'd1, 4'd9};
            else
                next = {value[7:4], value[3:0] - 4'd1};
        end
    end

endmodule

// File: rtl/alarm_time_set.sv
// Alarm time entry: edits go to shadow registers and reach the committed alarm
// digits only when edit mode is left, so the comparator never sees a partial time.
module alarm_time_set
    import alarm_pkg::*;
#(
    parameter logic [7:0]  RESET_HOUR    = RESET_HOUR_DEF,
    parameter logic [7:0]  RESET_MIN     = RESET_MIN_DEF,
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int unsigned BLINK_CYCLES  = BLINK_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    alarm_time_set_if.slave  bus
);

    localparam logic [31:0] HOLD_W   = 32'(HOLD_CYCLES);
    localparam logic [31:0] REPEAT_W = 32'(REPEAT_CYCLES);
    localparam logic [31:0] BLINK_W  = 32'(BLINK_CYCLES);

    state_e      state, state_nxt;
    logic        mode_q, sel_q, inc_q, dec_q;
    logic        mode_e, sel_e, inc_e, dec_e;
    logic [7:0]  al_hour, al_min, sh_hour, sh_min;
    logic [7:0]  step_value, step_max, step_next;
    logic [31:0] rpt_cnt, blink_cnt;
    logic        rpt_armed, rpt_phase, blink_q;
    logic        editing, restart, step_ok, edge_step, rpt_fire, do_step;

    // Previous samples start high so a key held through reset does not fire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b1;
            sel_q  <= 1'b1;
            inc_q  <= 1'b1;
            dec_q  <= 1'b1;
        end else begin
            mode_q <= bus.key_mode;
            sel_q  <= bus.key_sel;
            inc_q  <= bus.key_inc;
            dec_q  <= bus.key_dec;
        end
    end

    assign mode_e = bus.key_mode & ~mode_q;
    assign sel_e  = bus.key_sel  & ~sel_q;
    assign inc_e  = bus.key_inc  & ~inc_q;
    assign dec_e  = bus.key_dec  & ~dec_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (mode_e) state_nxt = ST_EDIT_HOUR;
            ST_EDIT_HOUR: if (mode_e) state_nxt = ST_IDLE;
                          else if (sel_e) state_nxt = ST_EDIT_MIN;
            ST_EDIT_MIN:  if (mode_e) state_nxt = ST_IDLE;
                          else if (sel_e) state_nxt = ST_EDIT_HOUR;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.edit_field = state;
        bus.blink      = blink_q;
    end

    assign editing = (state != ST_IDLE);
    assign restart = (state_nxt != ST_IDLE) && (state_nxt != state);

    // Mode and sel edges swallow any inc/dec in the same cycle.
    assign step_ok   = editing && !mode_e && !sel_e && (bus.key_inc ^ bus.key_dec);
    assign edge_step = step_ok && (bus.key_inc ? inc_e : dec_e);
    assign rpt_fire  = rpt_armed && ((rpt_cnt + 32'd1) == (rpt_phase ? REPEAT_W : HOLD_W));
    assign do_step   = edge_step || (step_ok && rpt_fire);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
            rpt_phase <= 1'b0;
        end else if (!step_ok) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
            rpt_phase <= 1'b0;
        end else if (edge_step) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b1;
            rpt_phase <= 1'b0;
        end else if (rpt_armed) begin
            if (rpt_fire) begin
                rpt_cnt   <= '0;
                rpt_phase <= 1'b1;
            end else begin
                rpt_cnt   <= rpt_cnt + 32'd1;
            end
        end
    end

    assign step_value = (state == ST_EDIT_MIN) ? sh_min  : sh_hour;
    assign step_max   = (state == ST_EDIT_MIN) ? MIN_MAX : HOUR_MAX;

    alarm_bcd_step u_step (
        .value (step_value),
        .max   (step_max),
        .up    (do_step & bus.key_inc),
        .down  (do_step & bus.key_dec),
        .next  (step_next)
    );

    // In IDLE the shadow tracks the committed time, so entering edit starts from it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            al_hour <= RESET_HOUR;
            al_min  <= RESET_MIN;
            sh_hour <= RESET_HOUR;
            sh_min  <= RESET_MIN;
        end else if (!editing) begin
            sh_hour <= al_hour;
            sh_min  <= al_min;
        end else if (mode_e) begin
            al_hour <= sh_hour;
            al_min  <= sh_min;
        end else if (do_step) begin
            if (state == ST_EDIT_MIN) sh_min  <= step_next;
            else                      sh_hour <= step_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_q   <= 1'b0;
            blink_cnt <= '0;
        end else if (state_nxt == ST_IDLE) begin
            blink_q   <= 1'b0;
            blink_cnt <= '0;
        end else if (restart) begin
            blink_q   <= 1'b1;
            blink_cnt <= '0;
        end else if ((blink_cnt + 32'd1) == BLINK_W) begin
            blink_q   <= ~blink_q;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 32'd1;
        end
    end

    assign bus.alarm_hour_10 = al_hour[7:4];
    assign bus.alarm_hour_01 = al_hour[3:0];
    assign bus.alarm_min_10  = al_min[7:4];
    assign bus.alarm_min_01  = al_min[3:0];
    assign bus.edit_hour_10  = sh_hour[7:4];
    assign bus.edit_hour_01  = sh_hour[3:0];
    assign bus.edit_min_10   = sh_min[7:4];
    assign bus.edit_min_01   = sh_min[3:0];

endmodule

// File: doc/alarm_time_set.md
Name: alarm_time_set

Overview:
Writer side of the alarm comparison path. It lets the user enter and edit the alarm time (HH:MM, BCD) with keys. It drives the committed alarm digits that the alarm comparator reads. Edits go into shadow registers and are committed only when edit mode is left, so the comparator never sees a partial time.

Parameters:
RESET_HOUR, 8'h06, committed alarm hour after reset (BCD, 00-23)
RESET_MIN, 8'h30, committed alarm minute after reset (BCD, 00-59)
HOLD_CYCLES, 50_000_000, cycles a key must stay held after its first step before auto-repeat starts
REPEAT_CYCLES, 10_000_000, cycles between auto-repeat steps
BLINK_CYCLES, 25_000_000, half-period of the blink output

Ports:
clk  in  1  system clock; only clock domain
rst  in  1  asynchronous, active-high reset
key_mode  in  1  level; debounced and synchronized upstream; enter/leave edit mode
key_sel  in  1  level; toggle the edited field between hour and minute
key_inc  in  1  level; increment the edited field
key_dec  in  1  level; decrement the edited field
alarm_hour_10  out  4  committed alarm hour tens (BCD)
alarm_hour_01  out  4  committed alarm hour units
alarm_min_10  out  4  committed alarm minute tens
alarm_min_01  out  4  committed alarm minute units
edit_hour_10, edit_hour_01, edit_min_10, edit_min_01  out  4 each  shadow digits for display
edit_field  out  2  00 idle, 01 hour, 10 minute
blink  out  1  blink enable for the edited field

Behaviour:
- Reset (async, rst=1):
  - committed and shadow digits = RESET_HOUR/RESET_MIN.
  - State IDLE; edit_field=00; blink=0; repeat and blink counters = 0.
  - Previous-key registers reset to 1, so a key held through reset does not fire.
- Key events: a rising edge is sampled high while the previous sample is low. The action is registered, so outputs change 1 cycle after the key is first sampled high.
- FSM:
  - IDLE: mode edge -> EDIT_HOUR and shadow loaded from committed. Other keys ignored.
  - EDIT_HOUR: sel edge -> EDIT_MIN. Mode edge -> IDLE and commit shadow to alarm_*, same edge.
  - EDIT_MIN: sel edge -> EDIT_HOUR. Mode edge -> IDLE with commit.
- Priority within one cycle: mode > sel > inc/dec. A lower-priority event in the same cycle is dropped, not deferred.
- inc and dec both active in the same cycle: no step, and the repeat counter is cleared.
- Arithmetic is two-digit BCD on the edited field only; there is no carry between minute and hour.
  - Hour: inc 23 -> 00; dec 00 -> 23.
  - Minute: inc 59 -> 00; dec 00 -> 59.
  - Units digit rolls 9 -> 0 with tens +1; on decrement, 0 -> 9 with tens -1.
- Auto-repeat:
  - While exactly one of inc/dec is held in an edit state, the counter counts from the edge step.
  - At HOLD_CYCLES a further step occurs, then one step every REPEAT_CYCLES.
  - Releasing the key, a field change, or a state change clears the counter.
- Blink: 0 in IDLE. On entry to an edit state or a field change, the counter clears and blink=1. blink toggles every BLINK_CYCLES while editing.
- Committed outputs change only on commit or reset. The shadow in IDLE mirrors committed.
- Reset mid-edit: shadow edits are discarded; committed returns to reset values.

Decomposition:
- Shared package alarm_pkg holds:
  - state encoding (IDLE/EDIT_HOUR/EDIT_MIN, matches edit_field);
  - BCD limits HOUR_MAX=8'h23, MIN_MAX=8'h59;
  - the reset-time defaults.
- One sub-module, alarm_bcd_step: combinational two-digit BCD step.
  - Inputs: value[7:0], max[7:0], up, down.
  - Output: next[7:0].
  - Instantiated once and muxed by field.

Test Plan (HOLD_CYCLES=4, REPEAT_CYCLES=2, BLINK_CYCLES=3):
1. Reset -> alarm 06:30, edit_field=00, blink=0. Hold key_inc through reset release -> no change.
2. mode edge, 4 inc edges, sel edge, 1 dec edge, mode edge -> alarm_* stays 06:30 until the final mode edge, then 10:29 one cycle later.
3. Hour 23 plus one inc -> 00. Minute 00 plus one dec -> 59. Hour is untouched by the minute wrap.
4. Edit hour from 06; hold key_inc for 12 cycles -> steps at cycles 1, 5, 7, 9, 11 -> hour 11. Release -> counting stops.
5. mode and inc edges in the same cycle from EDIT_MIN -> IDLE, commit of the pre-inc value. inc and dec together -> no step.
6. Assert rst mid-edit after changing hour to 09 -> alarm 06:30, IDLE, shadow 06:30. Blink toggles every 3 cycles in EDIT and is held at 0 in IDLE.
